// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: scan-code prefixes,
// frame-state encoding, key-word bit positions and the parity helper.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

    localparam int KEY_BRK = 9;
    localparam int KEY_EXT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// Key word bus between the PS/2 receiver (master) and the polling bus side (slave).
interface ps2_kbd_rx_if;
    logic       key_ack;
    logic [9:0] ps2kb_key;
    logic       key_valid;
    logic       key_pending;
    logic       overrun;
    logic       frame_err;

    modport master (
        input  key_ack,
        output ps2kb_key, key_valid, key_pending, overrun, frame_err
    );

    modport slave (
        output key_ack,
        input  ps2kb_key, key_valid, key_pending, overrun, frame_err
    );
endinterface

// File: rtl/ps2_kbd_rx_line_filter.sv
// Per-line input conditioning: two-flop synchroniser followed by a stability
// filter. The filtered level only follows the line once it has held a new
// value for FILTER_LEN consecutive clocks; it comes out of reset at the idle
// bus level of 1.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_out
);
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clk domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= line_in;
            sync2 <= sync1;
        end
    end

    // Count consecutive cycles of disagreement; adopt the new level when long enough
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_out <= 1'b1;
            cnt      <= '0;
        end else if (sync2 == line_out) begin
            cnt <= '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
            line_out <= sync2;
            cnt      <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: conditions both PS/2 lines, deframes 11-bit frames,
// folds E0/F0 prefixes into a 10-bit key word {break, extended, scan} and
// keeps a pending flag for a polling bus master.
// Optional build macro PS2_TYPEMATIC_FILTER_EN: suppress repeated make codes
// of the last pressed key until its break code arrives.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    ps2_kbd_rx_if.master    kb
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_f;
    logic          data_f;
    logic          clk_f_d;
    logic          fall;
    frame_state_t  state;
    frame_state_t  state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_err;
    logic [TW-1:0] timer;
    logic          accept;
    logic          err_c;
    logic          ext;
    logic          brk;
    logic          is_pfx;
    logic          drop;
    logic          emit;
    logic [9:0]    word;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .rst(rst), .line_in(ps2_clk), .line_out(clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk(clk), .rst(rst), .line_in(ps2_data), .line_out(data_f)
    );

    assign fall = clk_f_d & ~clk_f;

    // Delayed copy of the filtered PS/2 clock for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) clk_f_d <= 1'b1;
        else      clk_f_d <= clk_f;
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // Frame sequencing: one step per PS/2 clock fall, abort on a stalled frame
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        err_c      = 1'b0;
        if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!data_f) state_next = ST_DATA;
                    else         err_c      = 1'b1;
                end
                ST_DATA: begin
                    if (bit_cnt == 3'd7) state_next = ST_PARITY;
                end
                ST_PARITY: state_next = ST_STOP;
                ST_STOP: begin
                    state_next = ST_IDLE;
                    if (data_f && !par_err) accept = 1'b1;
                    else                    err_c  = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next = ST_IDLE;
            err_c      = 1'b1;
        end
    end

    // Bit counter, LSB-first shift register and latched parity result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            shift   <= '0;
            par_err <= 1'b0;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    par_err <= 1'b0;
                end
                ST_DATA: begin
                    shift   <= {data_f, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                ST_PARITY: par_err <= !odd_parity_ok(shift, data_f);
                default: ;
            endcase
        end
    end

    // Cycles since the last PS/2 clock fall while a frame is in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          timer <= '0;
        else if (state == ST_IDLE || fall) timer <= '0;
        else                               timer <= timer + TW'(1);
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] last_make;
    logic       last_vld;

    // Remember the last make word so auto-repeats can be swallowed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_make <= '0;
            last_vld  <= 1'b0;
        end else if (err_c) begin
            last_vld <= 1'b0;
        end else if (accept && !is_pfx) begin
            if (brk) begin
                if (last_vld && last_make == {ext, shift}) last_vld <= 1'b0;
            end else begin
                last_make <= {ext, shift};
                last_vld  <= 1'b1;
            end
        end
    end

    assign drop = !brk && last_vld && (last_make == {ext, shift});
`else
    assign drop = 1'b0;
`endif

    // Decide whether an accepted byte becomes a new key word
    always_comb begin
        word          = '0;
        word[KEY_BRK] = brk;
        word[KEY_EXT] = ext;
        word[7:0]     = shift;
        is_pfx        = (shift == PS2_PFX_EXT) || (shift == PS2_PFX_BRK);
        emit          = accept && !is_pfx && !drop;
    end

    // Prefix tracking and registered key / status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext          <= 1'b0;
            brk          <= 1'b0;
            kb.ps2kb_key <= '0;
            kb.key_valid <= 1'b0;
            kb.overrun   <= 1'b0;
            kb.frame_err <= 1'b0;
        end else begin
            kb.key_valid <= emit;
            kb.overrun   <= emit && kb.key_pending && !kb.key_ack;
            kb.frame_err <= err_c;
            if (err_c) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (accept) begin
                if (shift == PS2_PFX_EXT) begin
                    ext <= 1'b1;
                end else if (shift == PS2_PFX_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end
            if (emit) kb.ps2kb_key <= word;
        end
    end

    // Sticky pending flag; a new key wins over a simultaneous acknowledge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                kb.key_pending <= 1'b0;
        else if (kb.key_valid)   kb.key_pending <= 1'b1;
        else if (kb.key_ack)     kb.key_pending <= 1'b0;
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: drives PS/2 frames on the raw pins and
// compares the bus-side outputs with a frame-level reference model.
module tb_ps2_kbd_rx;
    localparam int FILT = 8;
    localparam int TMO  = 3000;

    logic clk      = 1'b0;
    logic rst      = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_kbd_rx_if kb ();

    ps2_kbd_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kb(kb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event counters seen on the bus side
    int valid_seen = 0, err_seen = 0, ovr_seen = 0, pend_rises = 0, last_valid_cyc = 0;
    logic prev_pending = 1'b0;
    always @(negedge clk) begin
        if (kb.key_valid) begin
            valid_seen++;
            last_valid_cyc = cyc;
        end
        if (kb.overrun)   ovr_seen++;
        if (kb.frame_err) err_seen++;
        if (kb.key_pending && !prev_pending) pend_rises++;
        prev_pending = kb.key_pending;
    end

    // Bus-side responder: 0 = never ack, 1 = ack the cycle after key_valid,
    // 2 = ack in the key_valid cycle; manual acks requested by count
    int ack_mode = 0;
    int manual_acks = 0;
    initial begin
        int acks_done;
        acks_done = 0;
        kb.key_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (manual_acks != acks_done) begin
                acks_done++;
                kb.key_ack = 1'b1;
                @(negedge clk);
                kb.key_ack = 1'b0;
            end else if (kb.key_valid && ack_mode != 0) begin
                if (ack_mode == 1) @(negedge clk);
                kb.key_ack = 1'b1;
                @(negedge clk);
                kb.key_ack = 1'b0;
            end
        end
    end

    // Reference model state
    logic [9:0] m_key = '0;
    int   m_valid = 0, m_err = 0, m_ovr = 0;
    bit   m_pending = 0, m_ext = 0, m_brk = 0, m_last_vld = 0;
    logic [8:0] m_last = '0;
    int   errors = 0, checks = 0, frame_no = 0;
    int   fall_cyc = 0, stop_fall_cyc = 0;

    task automatic checkOutput(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        checkOutput({tag, ".key"},     kb.ps2kb_key,   m_key);
        checkOutput({tag, ".valids"},  valid_seen,     m_valid);
        checkOutput({tag, ".errs"},    err_seen,       m_err);
        checkOutput({tag, ".ovr"},     ovr_seen,       m_ovr);
        checkOutput({tag, ".pending"}, kb.key_pending, m_pending);
    endtask

    task automatic send_bit(input bit b, input int half);
        @(negedge clk);
        ps2_data = b;
        repeat (half) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (half) @(negedge clk);
        ps2_clk  = 1'b1;
    endtask

    // Frame-level behaviour: prefixes, key words, typematic suppression, pending
    task automatic model_frame(input logic [7:0] b, input bit good, output bit emit);
        logic [9:0] w;
        emit = 0;
        if (!good) begin
            m_err++;
            m_ext = 0;
            m_brk = 0;
            m_last_vld = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            w = {m_brk, m_ext, b};
            emit = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!m_brk && m_last_vld && m_last == {m_ext, b}) emit = 0;
            if (m_brk) begin
                if (m_last_vld && m_last == {m_ext, b}) m_last_vld = 0;
            end else begin
                m_last = {m_ext, b};
                m_last_vld = 1;
            end
`endif
            m_ext = 0;
            m_brk = 0;
            if (emit) begin
                m_key = w;
                m_valid++;
                if (m_pending) m_ovr++;
                m_pending = (ack_mode == 1) ? 1'b0 : 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int half;
        bit emit;
        string tag;
        half = $urandom_range(25, 40);
        send_bit(1'b0, half);
        for (int i = 0; i < 8; i++) send_bit(b[i], half);
        send_bit((~^b) ^ bad_par, half);
        send_bit(!bad_stop, half);
        stop_fall_cyc = fall_cyc;
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
        model_frame(b, !bad_par && !bad_stop, emit);
        tag = $sformatf("frame%0d_%02h", frame_no, b);
        frame_no++;
        check_all(tag);
        if (emit)
            checkOutput({tag, ".latency_in_range"},
                        (last_valid_cyc - stop_fall_cyc >= FILT + 1) &&
                        (last_valid_cyc - stop_fall_cyc <= FILT + 4), 1);
    endtask

    initial begin
        int rises0;
        // Reset state
        repeat (4) @(negedge clk);
        checkOutput("reset.key",     kb.ps2kb_key,   0);
        checkOutput("reset.valid",   kb.key_valid,   0);
        checkOutput("reset.pending", kb.key_pending, 0);
        checkOutput("reset.ferr",    kb.frame_err,   0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Single make code, acknowledged the cycle after key_valid
        ack_mode = 1;
        rises0 = pend_rises;
        applyStimulus(8'h1C, 0, 0);
        checkOutput("t1.pend_rise", pend_rises - rises0, 1);

        // Extended make and extended break
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'h75, 0, 0);
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h75, 0, 0);

        // Parity error, then a good frame; a pending prefix is also discarded
        applyStimulus(8'hE0, 0, 0);
        applyStimulus(8'h1D, 1, 0);
        applyStimulus(8'h1D, 0, 0);

        // Stalled frame times out and clears a pending prefix
        applyStimulus(8'hE0, 0, 0);
        send_bit(1'b0, 30);
        send_bit(1'b1, 30);
        send_bit(1'b0, 30);
        send_bit(1'b1, 30);
        repeat (TMO - 100) @(negedge clk);
        checkOutput("t4.no_early_timeout", err_seen, m_err);
        repeat (300) @(negedge clk);
        m_err++;
        m_ext = 0;
        m_brk = 0;
        m_last_vld = 0;
        checkOutput("t4.timeout_err", err_seen, m_err);
        applyStimulus(8'h6B, 0, 0);

        // Start bit of 1 is a frame error on its own
        send_bit(1'b1, 30);
        repeat (30) @(negedge clk);
        m_err++;
        m_ext = 0;
        m_brk = 0;
        m_last_vld = 0;
        check_all("bad_start");

        // A short glitch on ps2_clk is filtered out
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        check_all("glitch");

        // Overrun without ack, then ack in the key_valid cycle
        ack_mode = 0;
        applyStimulus(8'h1C, 0, 0);
        applyStimulus(8'h1B, 0, 0);
        ack_mode = 2;
        applyStimulus(8'h2C, 0, 0);
        ack_mode = 0;
        manual_acks++;
        repeat (5) @(negedge clk);
        m_pending = 0;
        check_all("t5.manual_ack");

        // Typematic repeats followed by break
        ack_mode = 1;
        applyStimulus(8'h1D, 0, 0);
        applyStimulus(8'h1D, 0, 0);
        applyStimulus(8'h1D, 0, 0);
        applyStimulus(8'hF0, 0, 0);
        applyStimulus(8'h1D, 0, 0);

        // Randomised traffic
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 9);
            ack_mode = $urandom_range(0, 1);
            case (r)
                0:       applyStimulus(8'hE0, 0, 0);
                1:       applyStimulus(8'hF0, 0, 0);
                2:       applyStimulus(8'($urandom_range(0, 255)), 1, 0);
                3:       applyStimulus(8'($urandom_range(0, 255)), 0, 1);
                default: applyStimulus(8'($urandom_range(0, 255)), 0, 0);
            endcase
        end

        // Reset in the middle of a frame
        ack_mode = 0;
        applyStimulus(8'h4D, 0, 0);
        send_bit(1'b0, 30);
        send_bit(1'b1, 30);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid.key",     kb.ps2kb_key,   0);
        checkOutput("rst_mid.pending", kb.key_pending, 0);
        checkOutput("rst_mid.valid",   kb.key_valid,   0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        m_key = '0;
        m_pending = 0;
        m_ext = 0;
        m_brk = 0;
        m_last_vld = 0;
        repeat (20) @(negedge clk);
        applyStimulus(8'h5A, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
